regf_dump: RTL and testbench

Debug read-out engine on the core's register-file side. On a start pulse it walks a fixed range of the 64-bit integer register file through a dedicated read port and streams each register out as a framed byte stream with valid/ready flow control. It is the hardware counterpart of the self-check bench: it reads architectural state out of `risc_top` for a host or a UART bridge, and drives no core state.

---
 rtl/regf_dump_pkg.sv | 26 ++
 rtl/regf_dump.sv | 147 ++++++++++++++
 tb/tb_regf_dump.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regf_dump_pkg.sv
// regf_dump shared definitions: FSM states, frame marker bytes and
// per-register byte-count helpers.
package regf_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_IDX,
    S_DATA,
    S_CSUM,
    S_TRL,
    S_DONE
  } state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] TRL_BYTE = 8'h5A;

  localparam int XLEN_DEFAULT  = 64;
  localparam int BYTES_PER_REG = XLEN_DEFAULT / 8;

  function automatic int bytes_per_reg(input int xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/regf_dump.sv
// Register-file dump engine: walks FIRST_REG..LAST_REG through a read
// port and streams a framed, checksummed byte stream over valid/ready.
module regf_dump
  import regf_dump_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data,
  output logic            out_valid,
  output logic [7:0]      out_data,
  input  logic            out_ready
);

  localparam int BPR = bytes_per_reg(XLEN);
  localparam int CW  = (BPR > 1) ? $clog2(BPR) : 1;

  localparam logic [4:0]    FIRST    = 5'(FIRST_REG);
  localparam logic [4:0]    LAST     = 5'(LAST_REG);
  localparam logic [CW-1:0] CNT_LAST = CW'(BPR - 1);

  state_t          r_state;
  logic [4:0]      r_idx;
  logic [XLEN-1:0] r_shift;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_csum;
  logic            r_busy;
  logic            r_done;
  logic [4:0]      r_addr;
  logic            r_valid;
  logic [7:0]      r_data;

  logic            w_hs;
  logic [XLEN-1:0] w_shift_nxt;
  logic [7:0]      w_csum_nxt;

  assign w_hs        = r_valid && out_ready;
  assign w_shift_nxt = r_shift >> 8;
  assign w_csum_nxt  = r_csum ^ r_data;

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_addr   = r_addr;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  // Frame sequencer with registered stream, address and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= FIRST;
      r_shift <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_HDR;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_data  <= HDR_BYTE;
            r_csum  <= '0;
            r_idx   <= FIRST;
            r_addr  <= FIRST;
            r_cnt   <= '0;
          end
        end
        S_HDR: begin
          if (w_hs) begin
            r_state <= S_LOAD;
            r_valid <= 1'b0;
          end
        end
        S_LOAD: begin
          r_shift <= rd_data;
          r_state <= S_IDX;
          r_valid <= 1'b1;
          r_data  <= {3'b000, r_idx};
        end
        S_IDX: begin
          if (w_hs) begin
            r_state <= S_DATA;
            r_data  <= r_shift[7:0];
            r_cnt   <= '0;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            r_csum  <= w_csum_nxt;
            r_shift <= w_shift_nxt;
            if (r_cnt == CNT_LAST) begin
              if (r_idx == LAST) begin
                r_state <= S_CSUM;
                r_data  <= w_csum_nxt;
              end else begin
                r_state <= S_LOAD;
                r_valid <= 1'b0;
                r_idx   <= r_idx + 5'd1;
                r_addr  <= r_idx + 5'd1;
              end
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_data <= w_shift_nxt[7:0];
            end
          end
        end
        S_CSUM: begin
          if (w_hs) begin
            r_state <= S_TRL;
            r_data  <= TRL_BYTE;
          end
        end
        S_TRL: begin
          if (w_hs) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_addr  <= '0;
          r_idx   <= FIRST;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regf_dump.sv
// Self-checking bench for regf_dump: scoreboard of expected frame bytes
// compared against the accepted stream of two differently sized instances.
module tb_regf_dump;
  import regf_dump_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;
  logic [63:0] regs [0:31];

  logic        a_start, a_busy, a_done, a_valid;
  logic [4:0]  a_addr;
  logic [7:0]  a_data;
  logic [63:0] a_rdata;

  logic        b_start, b_busy, b_done, b_valid;
  logic [4:0]  b_addr;
  logic [7:0]  b_data;
  logic [63:0] b_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  always #5 clk = ~clk;

  assign a_rdata = regs[a_addr];
  assign b_rdata = regs[b_addr];

  regf_dump #(.XLEN(64), .FIRST_REG(1), .LAST_REG(7)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy),
    .done(a_done), .rd_addr(a_addr), .rd_data(a_rdata),
    .out_valid(a_valid), .out_data(a_data), .out_ready(out_ready)
  );

  regf_dump #(.XLEN(64), .FIRST_REG(31), .LAST_REG(31)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy),
    .done(b_done), .rd_addr(b_addr), .rd_data(b_rdata),
    .out_valid(b_valid), .out_data(b_data), .out_ready(out_ready)
  );

  // Reference frame: header, {idx, 8 LSB-first bytes}*, xor of data, trailer
  function automatic void push_frame(input int first, input int last);
    logic [7:0] cs;
    logic [7:0] byt;
    logic [4:0] ix;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int r = first; r <= last; r++) begin
      ix = 5'(r);
      exp_q.push_back({3'b000, ix});
      for (int b = 0; b < BYTES_PER_REG; b++) begin
        byt = regs[r][8*b +: 8];
        exp_q.push_back(byt);
        cs = cs ^ byt;
      end
    end
    exp_q.push_back(cs);
    exp_q.push_back(8'h5A);
  endfunction

  // Starts one frame and records accepted bytes until done (-1 on timeout)
  task automatic collect(input bit sel, input bit rnd, input bit restart,
                         input bit ovw, output int done_cyc,
                         output int unstable, output bit lat_ok);
    logic       v, bs, dn, ps;
    logic [7:0] d, pd;
    obs_q.delete();
    done_cyc = -1;
    unstable = 0;
    lat_ok   = 1'b0;
    ps       = 1'b0;
    pd       = 8'h00;
    @(negedge clk);
    if (sel) b_start = 1'b1;
    else     a_start = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      a_start = 1'b0;
      b_start = 1'b0;
      if (restart && (i == 20 || i == 45)) a_start = 1'b1;
      out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      #1;
      v  = sel ? b_valid : a_valid;
      bs = sel ? b_busy  : a_busy;
      dn = sel ? b_done  : a_done;
      d  = sel ? b_data  : a_data;
      if (i == 0) lat_ok = v && bs && (d == 8'hA5);
      if (ps && (!v || d !== pd)) unstable++;
      ps = v && !out_ready;
      pd = d;
      if (v && out_ready) begin
        obs_q.push_back(d);
        if (ovw && a_addr == 5'd2 && d == 8'h02)
          regs[2] = 64'hDEAD_BEEF_CAFE_F00D;
      end
      if (dn) begin
        done_cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    a_start   = 1'b0;
    b_start   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset busy: got %b want 0", a_busy);
    end
    n_cmp++;
    if (a_done !== 1'b0) begin
      n_bad++; $display("FAIL reset done: got %b want 0", a_done);
    end
    n_cmp++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset valid: got %b/%b want 0", a_valid, b_valid);
    end
    n_cmp++;
    if (a_data !== 8'h00) begin
      n_bad++; $display("FAIL reset data: got %02h want 00", a_data);
    end
    n_cmp++;
    if (a_addr !== 5'd0) begin
      n_bad++; $display("FAIL reset addr: got %0d want 0", a_addr);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int dc, us;
    bit lo;
    logic [7:0] e;
    push_frame(1, 7);
    collect(1'b0, 1'b0, 1'b0, 1'b0, dc, us, lo);
    n_cmp++;
    if (!lo) begin
      n_bad++; $display("FAIL basic latency: got 0 want 1 (A5 valid+busy)");
    end
    n_cmp++;
    if (dc !== 73) begin
      n_bad++; $display("FAIL basic done_cycle: got %0d want 73", dc);
    end
    n_cmp++;
    if (obs_q.size() != 66) begin
      n_bad++; $display("FAIL basic length: got %0d want 66", obs_q.size());
    end
    n_cmp++;
    if (obs_q.size() > 64 && obs_q[64] !== 8'h09) begin
      n_bad++; $display("FAIL basic csum: got %02h want 09", obs_q[64]);
    end
    foreach (obs_q[k]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (obs_q[k] !== e) begin
        n_bad++; $display("FAIL basic byte%0d: got %02h want %02h", k, obs_q[k], e);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL basic missing: got %0d left want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int dc, us;
    bit lo;
    logic [7:0] e;
    push_frame(1, 7);
    collect(1'b0, 1'b1, 1'b0, 1'b0, dc, us, lo);
    out_ready = 1'b1;
    n_cmp++;
    if (dc < 0) begin
      n_bad++; $display("FAIL bp done: got timeout want pulse");
    end
    n_cmp++;
    if (us != 0) begin
      n_bad++; $display("FAIL bp stable: got %0d changes want 0", us);
    end
    foreach (obs_q[k]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (obs_q[k] !== e) begin
        n_bad++; $display("FAIL bp byte%0d: got %02h want %02h", k, obs_q[k], e);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL bp missing: got %0d left want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_single_reg();
    int dc, us;
    bit lo;
    logic [7:0] e;
    regs[31] = 64'h0123_4567_89AB_CDEF;
    push_frame(31, 31);
    collect(1'b1, 1'b0, 1'b0, 1'b0, dc, us, lo);
    n_cmp++;
    if (dc !== 13) begin
      n_bad++; $display("FAIL single done_cycle: got %0d want 13", dc);
    end
    n_cmp++;
    if (obs_q.size() > 10 && obs_q[10] !== 8'h00) begin
      n_bad++; $display("FAIL single csum: got %02h want 00", obs_q[10]);
    end
    foreach (obs_q[k]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (obs_q[k] !== e) begin
        n_bad++; $display("FAIL single byte%0d: got %02h want %02h", k, obs_q[k], e);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL single missing: got %0d left want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int dc, us, stray;
    bit lo;
    logic [7:0] e;
    push_frame(1, 7);
    collect(1'b0, 1'b0, 1'b1, 1'b0, dc, us, lo);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i > 0 && (a_valid || a_busy)) stray++;
    end
    n_cmp++;
    if (stray != 0) begin
      n_bad++; $display("FAIL b2b stray: got %0d active cycles want 0", stray);
    end
    foreach (obs_q[k]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (obs_q[k] !== e) begin
        n_bad++; $display("FAIL b2b byte%0d: got %02h want %02h", k, obs_q[k], e);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL b2b missing: got %0d left want 0", exp_q.size());
    end
    exp_q.delete();
    push_frame(1, 7);
    collect(1'b0, 1'b0, 1'b0, 1'b0, dc, us, lo);
    foreach (obs_q[k]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (obs_q[k] !== e) begin
        n_bad++; $display("FAIL b2b2 byte%0d: got %02h want %02h", k, obs_q[k], e);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL b2b2 missing: got %0d left want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_abort();
    int dc, us, seen, extra, dpulse;
    bit lo;
    logic [7:0] e;
    seen   = 0;
    extra  = 0;
    dpulse = 0;
    @(negedge clk);
    a_start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a_start = 1'b0;
      #1;
      if (a_done) dpulse++;
      if (seen != 0) extra++;
      if (a_valid && a_addr == 5'd3 && a_data == 8'h03) seen = 1;
      if (extra == 3) break;
    end
    n_cmp++;
    if (seen == 0) begin
      n_bad++; $display("FAIL abort reach: got no x3 index byte want one");
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({a_busy, a_done, a_valid, a_data, a_addr} !== 16'h0) begin
      n_bad++; $display("FAIL abort outs: got b%b d%b v%b %02h a%0d want all 0",
                        a_busy, a_done, a_valid, a_data, a_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_done || a_valid) dpulse++;
    end
    n_cmp++;
    if (dpulse != 0) begin
      n_bad++; $display("FAIL abort done: got %0d events want 0", dpulse);
    end
    push_frame(1, 7);
    collect(1'b0, 1'b0, 1'b0, 1'b0, dc, us, lo);
    n_cmp++;
    if (dc !== 73) begin
      n_bad++; $display("FAIL abort refr done: got %0d want 73", dc);
    end
    foreach (obs_q[k]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (obs_q[k] !== e) begin
        n_bad++; $display("FAIL abort byte%0d: got %02h want %02h", k, obs_q[k], e);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL abort missing: got %0d left want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_overwrite();
    int dc, us;
    bit lo;
    logic [7:0] e;
    push_frame(1, 7);
    collect(1'b0, 1'b0, 1'b0, 1'b1, dc, us, lo);
    n_cmp++;
    if (regs[2] !== 64'hDEAD_BEEF_CAFE_F00D) begin
      n_bad++; $display("FAIL ovw applied: got %016h want deadbeefcafef00d", regs[2]);
    end
    foreach (obs_q[k]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (obs_q[k] !== e) begin
        n_bad++; $display("FAIL ovw byte%0d: got %02h want %02h", k, obs_q[k], e);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL ovw missing: got %0d left want 0", exp_q.size());
    end
    exp_q.delete();
    regs[2] = 64'd3;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = 64'(r) * 64'h0101_0101_0101_0101;
    regs[1] = 64'd5;
    regs[2] = 64'd3;
    regs[3] = 64'd11;
    regs[4] = 64'd17;
    regs[5] = 64'd29;
    regs[6] = 64'd8;
    regs[7] = 64'd0;
    test_reset();
    test_basic();
    test_backpressure();
    test_single_reg();
    test_back_to_back();
    test_reset_abort();
    test_overwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
